// File: rtl/feature_map_scheduler.sv
// feature_map_scheduler
//   Walks one feature map in raster order, one vector per accepted beat. It
//   drives the capture enable of the per-channel stream register and tags
//   every registered vector with its row/column. It sits between the layer
//   output buffer and the next layer's convolution window builder.
//
//   Optional feature: define FMS_ZERO_PAD_EN to scan a one-position zero
//   border around the map. Border beats select a zero vector through
//   pad_insert and never consume upstream data.
//
// Ports
//   clk            clock, all logic on posedge
//   rst_n          synchronous reset, active-low
//   start          pulse, begins a frame when idle
//   in_valid       upstream vector valid
//   in_ready       upstream may transfer this cycle
//   out_ready      downstream can take a vector next cycle
//   features_valid capture enable to the stream register (combinational)
//   pad_insert     select zero vector this beat (always 0 without padding)
//   out_valid      stream register holds a new vector (registered)
//   out_row        row tag of the vector at the stream output
//   out_col        column tag of the vector at the stream output
//   frame_done     one-cycle pulse while the last vector is at the output
//   busy           high from the accepted start through frame_done
module feature_map_scheduler #(
    parameter int MAP_WIDTH  = 28,
    parameter int MAP_HEIGHT = 28,
    parameter int COL_W      = $clog2(MAP_WIDTH + 2),
    parameter int ROW_W      = $clog2(MAP_HEIGHT + 2)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             out_ready,
    output logic             features_valid,
    output logic             pad_insert,
    output logic             out_valid,
    output logic [ROW_W-1:0] out_row,
    output logic [COL_W-1:0] out_col,
    output logic             frame_done,
    output logic             busy
);

`ifdef FMS_ZERO_PAD_EN
    localparam int GRID_W = MAP_WIDTH + 2;
    localparam int GRID_H = MAP_HEIGHT + 2;
`else
    localparam int GRID_W = MAP_WIDTH;
    localparam int GRID_H = MAP_HEIGHT;
`endif

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(GRID_W - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(GRID_H - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t           state_r;
    logic [ROW_W-1:0] row_r;
    logic [COL_W-1:0] col_r;
    logic             out_valid_r;
    logic [ROW_W-1:0] out_row_r;
    logic [COL_W-1:0] out_col_r;
    logic             frame_done_r;
    logic             busy_r;

    logic             in_ready_s;
    logic             beat_s;
    logic             pad_s;
    logic             at_last_s;

`ifdef FMS_ZERO_PAD_EN
    logic             border_s;

    // Border detection on the padded grid: first/last row or column
    always_comb begin
        border_s = 1'b0;
        if ((row_r == '0) || (row_r == LAST_ROW) ||
            (col_r == '0) || (col_r == LAST_COL)) begin
            border_s = 1'b1;
        end else begin
            border_s = 1'b0;
        end
    end
`endif

    // Handshake decode: beats only in STREAM and only when downstream can take one
    always_comb begin
        in_ready_s = 1'b0;
        beat_s     = 1'b0;
        pad_s      = 1'b0;
        if (state_r == ST_STREAM) begin
`ifdef FMS_ZERO_PAD_EN
            if (border_s) begin
                // Zero vector is generated locally, upstream is not consulted
                pad_s      = 1'b1;
                in_ready_s = 1'b0;
                beat_s     = out_ready;
            end else begin
                pad_s      = 1'b0;
                in_ready_s = out_ready;
                beat_s     = in_valid & out_ready;
            end
`else
            in_ready_s = out_ready;
            beat_s     = in_valid & out_ready;
`endif
        end else begin
            in_ready_s = 1'b0;
            beat_s     = 1'b0;
            pad_s      = 1'b0;
        end
    end

    // Last raster position of the scanned grid
    always_comb begin
        at_last_s = 1'b0;
        if ((row_r == LAST_ROW) && (col_r == LAST_COL)) begin
            at_last_s = 1'b1;
        end else begin
            at_last_s = 1'b0;
        end
    end

    // Frame FSM, raster counters and one-cycle-latency output tags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            row_r        <= '0;
            col_r        <= '0;
            out_valid_r  <= 1'b0;
            out_row_r    <= '0;
            out_col_r    <= '0;
            frame_done_r <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            // The output stage simply mirrors the beat of the previous cycle
            out_valid_r  <= beat_s;
            frame_done_r <= beat_s & at_last_s;
            if (beat_s) begin
                out_row_r <= row_r;
                out_col_r <= col_r;
            end

            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r <= ST_STREAM;
                        row_r   <= '0;
                        col_r   <= '0;
                        busy_r  <= 1'b1;
                    end
                end
                ST_STREAM: begin
                    if (beat_s) begin
                        if (col_r == LAST_COL) begin
                            col_r <= '0;
                            // Row stays at the last row when the frame ends
                            if (row_r == LAST_ROW) begin
                                state_r <= ST_DONE;
                            end else begin
                                row_r <= row_r + ROW_W'(1);
                            end
                        end else begin
                            col_r <= col_r + COL_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready       = in_ready_s;
    assign features_valid = beat_s;
    assign pad_insert     = pad_s;
    assign out_valid      = out_valid_r;
    assign out_row        = out_row_r;
    assign out_col        = out_col_r;
    assign frame_done     = frame_done_r;
    assign busy           = busy_r;

endmodule

// File: tb/tb_feature_map_scheduler.sv
// Directed bench for feature_map_scheduler. Default build uses a 3x4 map;
// with FMS_ZERO_PAD_EN it uses a 2x2 map scanned as a 4x4 padded grid.
module tb_feature_map_scheduler;

`ifdef FMS_ZERO_PAD_EN
    localparam int MW = 2;
    localparam int MH = 2;
    localparam int GW = 4;
    localparam int GH = 4;
    localparam bit PAD = 1'b1;
`else
    localparam int MW = 4;
    localparam int MH = 3;
    localparam int GW = 4;
    localparam int GH = 3;
    localparam bit PAD = 1'b0;
`endif
    localparam int NPOS  = GW * GH;
    localparam int COL_W = $clog2(MW + 2);
    localparam int ROW_W = $clog2(MH + 2);

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             in_valid;
    logic             in_ready;
    logic             out_ready;
    logic             features_valid;
    logic             pad_insert;
    logic             out_valid;
    logic [ROW_W-1:0] out_row;
    logic [COL_W-1:0] out_col;
    logic             frame_done;
    logic             busy;

    int checks;
    int failures;

    feature_map_scheduler #(
        .MAP_WIDTH (MW),
        .MAP_HEIGHT(MH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .out_ready     (out_ready),
        .features_valid(features_valid),
        .pad_insert    (pad_insert),
        .out_valid     (out_valid),
        .out_row       (out_row),
        .out_col       (out_col),
        .frame_done    (frame_done),
        .busy          (busy)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic bit is_border(input int idx);
        int r;
        int c;
        r = idx / GW;
        c = idx % GW;
        return PAD && ((r == 0) || (r == GH - 1) || (c == 0) || (c == GW - 1));
    endfunction

    // Runs one frame from start to idle, checking every cycle against a
    // raster-position model. stall_at: beat count at which out_ready drops
    // for 3 cycles (-1 none); toggle: in_valid alternates 1,0,...;
    // mid_start: pulse start during STREAM; dn_start: pulse start during DONE.
    task automatic run_frame(input int stall_at, input bit toggle,
                             input bit mid_start, input bit dn_start);
        int  beats;
        int  dut_beats;
        int  cyc_n;
        int  stall_left;
        bit  stall_used;
        bit  prev_beat;
        bit  brd;
        bit  exp_fv;
        bit  exp_rdy;
        beats      = 0;
        dut_beats  = 0;
        cyc_n      = 0;
        stall_left = 0;
        stall_used = 1'b0;
        prev_beat  = 1'b0;

        start     = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("idle_fv", features_valid, 1'b0);
        tick();
        start = 1'b0;

        while (beats < NPOS && cyc_n < 200) begin
            if (stall_at >= 0 && beats == stall_at && !stall_used) begin
                stall_left = 3;
                stall_used = 1'b1;
            end
            out_ready = (stall_left == 0);
            in_valid  = toggle ? ((cyc_n % 2) == 0) : 1'b1;
            start     = mid_start && (cyc_n == 3);
            #1;
            brd     = is_border(beats);
            exp_rdy = brd ? 1'b0 : out_ready;
            exp_fv  = brd ? out_ready : (in_valid & out_ready);
            chk("features_valid", features_valid, exp_fv);
            chk("in_ready", in_ready, exp_rdy);
            chk("pad_insert", pad_insert, brd);
            chk("busy_stream", busy, 1'b1);
            chk("out_valid", out_valid, prev_beat);
            if (beats > 0) begin
                chk("out_row", out_row, (beats - 1) / GW);
                chk("out_col", out_col, (beats - 1) % GW);
            end
            chk("frame_done_mid", frame_done, 1'b0);
            if (features_valid === 1'b1) dut_beats++;
            if (stall_left > 0) stall_left--;
            prev_beat = exp_fv;
            if (exp_fv) beats++;
            tick();
            cyc_n++;
        end
        start = 1'b0;
        chk("beat_budget", (cyc_n < 200), 1'b1);
        chk("total_beats", dut_beats, NPOS);

        // DONE cycle: last vector at output together with frame_done
        start = dn_start;
        #1;
        chk("done_valid", out_valid, 1'b1);
        chk("done_row", out_row, GH - 1);
        chk("done_col", out_col, GW - 1);
        chk("done_pulse", frame_done, 1'b1);
        chk("done_busy", busy, 1'b1);
        chk("done_ready", in_ready, 1'b0);
        chk("done_fv", features_valid, 1'b0);
        tick();
        start = 1'b0;
        #1;
        chk("post_busy", busy, 1'b0);
        chk("post_done", frame_done, 1'b0);
        chk("post_valid", out_valid, 1'b0);
        chk("post_fv", features_valid, 1'b0);
        tick();
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        tick();
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_row", out_row, 0);
        chk("rst_col", out_col, 0);
        chk("rst_done", frame_done, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ready", in_ready, 1'b0);
        chk("rst_fv", features_valid, 1'b0);
        chk("rst_pad", pad_insert, 1'b0);
        rst_n = 1'b1;
        tick();
        chk("idle_busy", busy, 1'b0);

        // Full-speed frame
        run_frame(-1, 1'b0, 1'b0, 1'b0);
        // Downstream stall after the 5th beat
        run_frame(5, 1'b0, 1'b0, 1'b0);
        // in_valid toggling
        run_frame(-1, 1'b1, 1'b0, 1'b0);
        // start pulses during STREAM and DONE are ignored
        run_frame(-1, 1'b0, 1'b1, 1'b1);

        // Reset mid-frame after 7 beats
        start     = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        chk("pre_rst_busy", busy, 1'b1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("abort_valid", out_valid, 1'b0);
        chk("abort_done", frame_done, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_fv", features_valid, 1'b0);
        tick();
        chk("abort_done2", frame_done, 1'b0);
        // New frame restarts at (0,0)
        run_frame(-1, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
